draw_string: RTL and testbench
==============================

DRAW_STRING -- requirements
Module: draw_string

Interface
REQ-001 Parameters (name, default, meaning): PIXEL_X_WIDTH 10 x width; PIXEL_Y_WIDTH 9 y width; PIXEL_X_MAX 639 last column; PIXEL_Y_MAX 479 last row; COLOR_ID_WIDTH 8 colour id; CHAR_CODE_WIDTH 8 char code; BUF_DEPTH 16 string buffer entries; BUF_ADDR_WIDTH 4 buffer index.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 buf_wren, buf_addr[BUF_ADDR_WIDTH], buf_data[CHAR_CODE_WIDTH]  in  string buffer write port.
REQ-005 start  in  1  one-cycle request to draw buffer entries 0..len-1.
REQ-006 x[PIXEL_X_WIDTH], y[PIXEL_Y_WIDTH], len[BUF_ADDR_WIDTH+1], size[4], fg/bg[COLOR_ID_WIDTH]  in  origin, char count, scale, colours; sampled on accepted start.
REQ-007 busy  out  1 ; done  out  1 one-cycle pulse ; err  out  1 clipped-string flag.
REQ-008 ch_x, ch_y, ch_code, ch_size[4], ch_mode[2], ch_fg, ch_bg, ch_vld  out  per-character command to the character renderer.
REQ-009 ch_done  in  1  renderer completion pulse.

Function
REQ-010 FSM states IDLE, ISSUE, WAIT, NEXT, FIN; reset state IDLE.
REQ-011 IDLE: start=1 latches inputs, clears err, sets idx=0, cur_x=x, cur_y=y; go ISSUE if len!=0, else FIN.
REQ-012 start while busy=1 is ignored; busy=1 in every state except IDLE.
REQ-013 buf_wren writes buffer only in IDLE; ignored while busy.
REQ-014 ISSUE: ch_vld=1 for exactly one cycle with ch_code=buf[idx], ch_x=cur_x, ch_y=cur_y, ch_mode=2'b10, latched size/fg/bg; go WAIT.
REQ-015 Latency: start at cycle N -> ch_vld at N+1.
REQ-016 WAIT: hold until ch_done=1, then NEXT; ch_done in any other state ignored.
REQ-017 NEXT: idx+1; pitch_x=6*(size+1), pitch_y=10*(size+1), computed in PIXEL_X_WIDTH+1 / PIXEL_Y_WIDTH+1 bits without truncation.
REQ-018 NEXT: if idx+1==len go FIN; else cur_x+=pitch_x.
REQ-019 Line wrap: if new cur_x+pitch_x-1 > PIXEL_X_MAX, cur_x=latched x, cur_y+=pitch_y.
REQ-020 Clip: if wrapped cur_y+pitch_y-1 > PIXEL_Y_MAX, set err=1, go FIN without issuing remaining characters.
REQ-021 From NEXT (non-terminal) go ISSUE; ch_done->next ch_vld exactly 2 cycles.
REQ-022 FIN: done=1 one cycle, go IDLE; err holds until next accepted start.
REQ-023 len > BUF_DEPTH saturates to BUF_DEPTH.
REQ-024 ch_* outputs hold last value when ch_vld=0.

Reset
REQ-025 rst_n=0 asynchronously forces IDLE; busy, done, err, ch_vld, ch_x, ch_y, ch_code, ch_size, ch_mode, ch_fg, ch_bg all 0; buffer contents undefined.
REQ-026 Reset mid-string abandons it; no done pulse; first start after release behaves as fresh.

Configuration
REQ-027 Macro DRAW_STRING_SKIP_SPACE_EN: defined -> code 8'h20 not issued (ISSUE->NEXT directly, no ch_vld, x still advances); undefined -> 8'h20 issued like any code.

Verification
REQ-028 Load "12" at 0..1, start x=10 y=20 len=2 size=0, ch_done 5 cycles after each ch_vld -> ch_vld (10,20,8'h31) then (16,20,8'h32), one done, err=0.
REQ-029 len=0 start -> no ch_vld, done one cycle after busy rises.
REQ-030 x=630 size=0 len=3 -> commands at (630,y), wrapped (630,y+10)... every x+5<=639 after wrap.
REQ-031 y=470 size=0 x=636 len=2 -> first char issued, second wraps to y=480 -> err=1, done, no second ch_vld.
REQ-032 Start pulse and buf_wren during WAIT -> ignored; drop rst_n during WAIT -> all outputs 0 immediately, no done.
REQ-033 With DRAW_STRING_SKIP_SPACE_EN, "A B" size=1 x=0 -> ch_vld at x=0 and x=24 only; without macro, three ch_vld at 0,12,24.

Source files
------------

// File: rtl/draw_string.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : draw_string                                                      |
// | Desc    : Walks a small character buffer and issues one renderer command  |
// |           per character with line wrap and bottom-edge clipping.           |
// |           Optional DRAW_STRING_SKIP_SPACE_EN suppresses commands for 8'h20.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module draw_string #(
   parameter int PIXEL_X_WIDTH   = 10,
   parameter int PIXEL_Y_WIDTH   = 9,
   parameter int PIXEL_X_MAX     = 639,
   parameter int PIXEL_Y_MAX     = 479,
   parameter int COLOR_ID_WIDTH  = 8,
   parameter int CHAR_CODE_WIDTH = 8,
   parameter int BUF_DEPTH       = 16,
   parameter int BUF_ADDR_WIDTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       buf_wren,
   input  logic [BUF_ADDR_WIDTH-1:0]  buf_addr,
   input  logic [CHAR_CODE_WIDTH-1:0] buf_data,
   input  logic                       start,
   input  logic [PIXEL_X_WIDTH-1:0]   x,
   input  logic [PIXEL_Y_WIDTH-1:0]   y,
   input  logic [BUF_ADDR_WIDTH:0]    len,
   input  logic [3:0]                 size,
   input  logic [COLOR_ID_WIDTH-1:0]  fg,
   input  logic [COLOR_ID_WIDTH-1:0]  bg,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [PIXEL_X_WIDTH-1:0]   ch_x,
   output logic [PIXEL_Y_WIDTH-1:0]   ch_y,
   output logic [CHAR_CODE_WIDTH-1:0] ch_code,
   output logic [3:0]                 ch_size,
   output logic [1:0]                 ch_mode,
   output logic [COLOR_ID_WIDTH-1:0]  ch_fg,
   output logic [COLOR_ID_WIDTH-1:0]  ch_bg,
   output logic                       ch_vld,
   input  logic                       ch_done
);

   localparam int         c_XW   = PIXEL_X_WIDTH + 2;
   localparam int         c_YW   = PIXEL_Y_WIDTH + 2;
   localparam int         c_LW   = BUF_ADDR_WIDTH + 1;
   localparam logic [1:0] c_MODE = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      NEXT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t                     r_state;
   logic [CHAR_CODE_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic [PIXEL_X_WIDTH-1:0]   r_x;
   logic [PIXEL_X_WIDTH-1:0]   r_cur_x;
   logic [PIXEL_Y_WIDTH-1:0]   r_cur_y;
   logic [c_LW-1:0]            r_len;
   logic [c_LW-1:0]            r_idx;
   logic [3:0]                 r_size;
   logic [COLOR_ID_WIDTH-1:0]  r_fg;
   logic [COLOR_ID_WIDTH-1:0]  r_bg;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_err;
   logic                       r_ch_vld;
   logic [PIXEL_X_WIDTH-1:0]   r_ch_x;
   logic [PIXEL_Y_WIDTH-1:0]   r_ch_y;
   logic [CHAR_CODE_WIDTH-1:0] r_ch_code;
   logic [3:0]                 r_ch_size;
   logic [1:0]                 r_ch_mode;
   logic [COLOR_ID_WIDTH-1:0]  r_ch_fg;
   logic [COLOR_ID_WIDTH-1:0]  r_ch_bg;

   logic [c_LW-1:0]            w_len_sat;
   logic [c_LW-1:0]            w_idx_n;
   logic [CHAR_CODE_WIDTH-1:0] w_code0;
   logic [CHAR_CODE_WIDTH-1:0] w_code_n;
   logic                       w_skip0;
   logic                       w_skip_n;
   logic [4:0]                 w_scale;
   logic [c_XW-1:0]            w_pitch_x;
   logic [c_YW-1:0]            w_pitch_y;
   logic [c_XW-1:0]            w_nx;
   logic [c_XW-1:0]            w_nx_end;
   logic [c_YW-1:0]            w_ny;
   logic [c_YW-1:0]            w_ny_end;
   logic                       w_wrap;
   logic                       w_clip;
   logic [PIXEL_X_WIDTH-1:0]   w_new_x;
   logic [PIXEL_Y_WIDTH-1:0]   w_new_y;

   assign w_len_sat = (len > c_LW'(BUF_DEPTH)) ? c_LW'(BUF_DEPTH) : len;
   assign w_idx_n   = r_idx + c_LW'(1);
   assign w_code0   = r_buf[0];
   assign w_code_n  = r_buf[w_idx_n[BUF_ADDR_WIDTH-1:0]];

`ifdef DRAW_STRING_SKIP_SPACE_EN
   localparam logic [CHAR_CODE_WIDTH-1:0] c_SPACE = CHAR_CODE_WIDTH'(8'h20);
   assign w_skip0  = (w_code0 == c_SPACE);
   assign w_skip_n = (w_code_n == c_SPACE);
`else
   assign w_skip0  = 1'b0;
   assign w_skip_n = 1'b0;
`endif

   // Pitch arithmetic is carried two bits wider than the pixel axes so that
   // the end-of-glyph sums can never wrap around before the bound compare.
   assign w_scale   = {1'b0, r_size} + 5'd1;
   assign w_pitch_x = c_XW'(w_scale) * c_XW'(6);
   assign w_pitch_y = c_YW'(w_scale) * c_YW'(10);
   assign w_nx      = c_XW'(r_cur_x) + w_pitch_x;
   assign w_nx_end  = w_nx + w_pitch_x - c_XW'(1);
   assign w_ny      = c_YW'(r_cur_y) + w_pitch_y;
   assign w_ny_end  = w_ny + w_pitch_y - c_YW'(1);
   assign w_wrap    = (w_nx_end > c_XW'(PIXEL_X_MAX));
   assign w_clip    = w_wrap && (w_ny_end > c_YW'(PIXEL_Y_MAX));
   assign w_new_x   = w_wrap ? r_x : w_nx[PIXEL_X_WIDTH-1:0];
   assign w_new_y   = w_wrap ? w_ny[PIXEL_Y_WIDTH-1:0] : r_cur_y;

   always_ff @(posedge clk) begin
      if (buf_wren && (r_state == IDLE) && (int'(buf_addr) < BUF_DEPTH))
         r_buf[buf_addr] <= buf_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_cur_x   <= '0;
         r_cur_y   <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_size    <= '0;
         r_fg      <= '0;
         r_bg      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_ch_vld  <= 1'b0;
         r_ch_x    <= '0;
         r_ch_y    <= '0;
         r_ch_code <= '0;
         r_ch_size <= '0;
         r_ch_mode <= '0;
         r_ch_fg   <= '0;
         r_ch_bg   <= '0;
      end else begin
         r_done   <= 1'b0;
         r_ch_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_x     <= x;
                  r_cur_x <= x;
                  r_cur_y <= y;
                  r_len   <= w_len_sat;
                  r_size  <= size;
                  r_fg    <= fg;
                  r_bg    <= bg;
                  r_err   <= 1'b0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  if (w_len_sat == '0) begin
                     r_state <= FIN;
                  end else begin
                     r_state <= ISSUE;
                     if (!w_skip0) begin
                        r_ch_vld  <= 1'b1;
                        r_ch_x    <= x;
                        r_ch_y    <= y;
                        r_ch_code <= w_code0;
                        r_ch_size <= size;
                        r_ch_mode <= c_MODE;
                        r_ch_fg   <= fg;
                        r_ch_bg   <= bg;
                     end
                  end
               end
            end
            // A suppressed character never raised ch_vld, so skip the wait.
            ISSUE: r_state <= r_ch_vld ? WAIT : NEXT;
            WAIT: begin
               if (ch_done)
                  r_state <= NEXT;
            end
            NEXT: begin
               r_idx <= w_idx_n;
               if (w_idx_n == r_len) begin
                  r_state <= FIN;
               end else if (w_clip) begin
                  r_err   <= 1'b1;
                  r_state <= FIN;
               end else begin
                  r_cur_x <= w_new_x;
                  r_cur_y <= w_new_y;
                  r_state <= ISSUE;
                  if (!w_skip_n) begin
                     r_ch_vld  <= 1'b1;
                     r_ch_x    <= w_new_x;
                     r_ch_y    <= w_new_y;
                     r_ch_code <= w_code_n;
                     r_ch_size <= r_size;
                     r_ch_mode <= c_MODE;
                     r_ch_fg   <= r_fg;
                     r_ch_bg   <= r_bg;
                  end
               end
            end
            FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign ch_vld  = r_ch_vld;
   assign ch_x    = r_ch_x;
   assign ch_y    = r_ch_y;
   assign ch_code = r_ch_code;
   assign ch_size = r_ch_size;
   assign ch_mode = r_ch_mode;
   assign ch_fg   = r_ch_fg;
   assign ch_bg   = r_ch_bg;

endmodule
`default_nettype wire

// File: tb/tb_draw_string.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_draw_string                                                   |
// | Desc    : Randomized self-checking bench for draw_string with a text-level |
// |           reference model of placement, wrap, clip and skip behaviour.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_draw_string;

`ifdef DRAW_STRING_SKIP_SPACE_EN
   localparam bit c_SKIP = 1'b1;
`else
   localparam bit c_SKIP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       buf_wren = 1'b0;
   logic [3:0] buf_addr = '0;
   logic [7:0] buf_data = '0;
   logic       start = 1'b0;
   logic [9:0] x = '0;
   logic [8:0] y = '0;
   logic [4:0] len = '0;
   logic [3:0] size = '0;
   logic [7:0] fg = '0;
   logic [7:0] bg = '0;
   logic       ch_done = 1'b0;
   logic       busy, done, err, ch_vld;
   logic [9:0] ch_x;
   logic [8:0] ch_y;
   logic [7:0] ch_code, ch_fg, ch_bg;
   logic [3:0] ch_size;
   logic [1:0] ch_mode;

   always #5 clk = ~clk;

   draw_string dut (
      .clk(clk), .rst_n(rst_n), .buf_wren(buf_wren), .buf_addr(buf_addr),
      .buf_data(buf_data), .start(start), .x(x), .y(y), .len(len),
      .size(size), .fg(fg), .bg(bg), .busy(busy), .done(done), .err(err),
      .ch_x(ch_x), .ch_y(ch_y), .ch_code(ch_code), .ch_size(ch_size),
      .ch_mode(ch_mode), .ch_fg(ch_fg), .ch_bg(ch_bg), .ch_vld(ch_vld),
      .ch_done(ch_done)
   );

   int n_chk = 0;
   int n_bad = 0;
   int model_buf [16];

   typedef struct {
      int px;
      int py;
      int code;
      int skips;
   } cmd_t;
   cmd_t exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input int d);
      buf_wren = 1'b1;
      buf_addr = 4'(a);
      buf_data = 8'(d);
      step();
      buf_wren = 1'b0;
      model_buf[a] = d;
   endtask

   // Reference placement: characters march right by 6*(size+1); a glyph that
   // would cross the right edge restarts at the origin column one text row
   // lower; a row that would cross the bottom edge aborts the string.
   task automatic build_model(input int sx, input int sy, input int sl, input int ss,
                              output bit e);
      int pw, ph, n, cx, cy, sk;
      exp_q.delete();
      pw = 6 * (ss + 1);
      ph = 10 * (ss + 1);
      n  = (sl > 16) ? 16 : sl;
      cx = sx;
      cy = sy;
      sk = 0;
      e  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            cx = cx + pw;
            if (cx + pw - 1 > 639) begin
               cx = sx;
               cy = cy + ph;
               if (cy + ph - 1 > 479) begin
                  e = 1'b1;
                  break;
               end
            end
         end
         if (c_SKIP && model_buf[i] == 32) begin
            sk++;
         end else begin
            exp_q.push_back('{cx, cy, model_buf[i], sk});
            sk = 0;
         end
      end
   endtask

   task automatic run_str(input int sx, input int sy, input int sl, input int ss,
                          input int fixed_dly);
      bit   e, fin;
      int   exp_n, cyc, got, done_at, last_done, lx, lc, fge, bge, gap;
      cmd_t c;
      build_model(sx, sy, sl, ss, e);
      exp_n = exp_q.size();
      fge = $urandom_range(0, 255);
      bge = $urandom_range(0, 255);
      x = 10'(sx); y = 9'(sy); len = 5'(sl); size = 4'(ss);
      fg = 8'(fge); bg = 8'(bge);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0; got = 0; done_at = -1; last_done = 0; lx = 0; lc = 0; fin = 1'b0;
      while (!fin && cyc < 600) begin
         if (cyc == 0) check("busy_rise", busy, 1);
         if (ch_vld) begin
            if (exp_q.size() == 0) begin
               check("extra_vld", 1, 0);
            end else begin
               c = exp_q.pop_front();
               gap = (got == 0) ? 2 * c.skips : 2 + 2 * c.skips;
               check("vld_gap", cyc - last_done, gap);
               check("ch_x", ch_x, c.px);
               check("ch_y", ch_y, c.py);
               check("ch_code", ch_code, c.code);
               check("ch_size", ch_size, ss);
               check("ch_mode", ch_mode, 2);
               check("ch_fg", ch_fg, fge);
               check("ch_bg", ch_bg, bge);
               got++;
               lx = c.px;
               lc = c.code;
               done_at = cyc + ((fixed_dly > 0) ? fixed_dly : $urandom_range(1, 6));
            end
         end else if (got > 0 && !done) begin
            check("hold_x", ch_x, lx);
            check("hold_code", ch_code, lc);
         end
         if (done) begin
            fin = 1'b1;
            check("done_busy", busy, 0);
            check("err", err, e);
            check("n_cmds", got, exp_n);
            if (sl == 0) check("len0_done_cyc", cyc, 1);
         end else begin
            if (cyc == done_at) begin
               ch_done   = 1'b1;
               last_done = cyc;
            end
            if (busy && $urandom_range(0, 7) == 0) begin
               start = 1'b1;
               x = 10'($urandom_range(0, 639));
               y = 9'($urandom_range(0, 479));
               len = 5'($urandom_range(0, 31));
               size = 4'($urandom_range(0, 15));
               fg = 8'($urandom_range(0, 255));
               bg = 8'($urandom_range(0, 255));
            end
            if (busy && $urandom_range(0, 7) == 0) begin
               buf_wren = 1'b1;
               buf_addr = 4'($urandom_range(0, 15));
               buf_data = 8'($urandom_range(0, 255));
            end
            step();
            cyc++;
            start = 1'b0;
            buf_wren = 1'b0;
            ch_done = 1'b0;
         end
      end
      if (!fin) check("timeout", 0, 1);
      step();
      check("done_pulse", done, 0);
      check("err_hold", err, e);
   endtask

   task automatic reset_mid();
      int n;
      load(0, 8'h41);
      load(1, 8'h42);
      x = 10'd100; y = 9'd100; len = 5'd2; size = 4'd0; fg = 8'd1; bg = 8'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!ch_vld && n < 20) begin
         step();
         n++;
      end
      check("rst_vld_seen", ch_vld, 1);
      step();
      step();
      start = 1'b1; buf_wren = 1'b1; buf_addr = 4'd0; buf_data = 8'h5A;
      x = 10'd0; y = 9'd0;
      step();
      start = 1'b0; buf_wren = 1'b0;
      check("wait_ign_start", ch_vld, 0);
      check("wait_busy", busy, 1);
      #3 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_vld", ch_vld, 0);
      check("rst_x", ch_x, 0);
      check("rst_y", ch_y, 0);
      check("rst_code", ch_code, 0);
      check("rst_size", ch_size, 0);
      check("rst_mode", ch_mode, 0);
      check("rst_fg", ch_fg, 0);
      check("rst_bg", ch_bg, 0);
      repeat (3) begin
         step();
         check("rst_no_done", done, 0);
      end
      rst_n = 1'b1;
      step();
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      step();
      step();
      check("init_busy", busy, 0);
      check("init_done", done, 0);
      check("init_err", err, 0);
      check("init_vld", ch_vld, 0);
      check("init_code", ch_code, 0);
      check("init_mode", ch_mode, 0);
      rst_n = 1'b1;
      step();

      load(0, 8'h31);
      load(1, 8'h32);
      run_str(10, 20, 2, 0, 5);
      run_str(0, 0, 0, 0, 1);
      load(0, 8'h41); load(1, 8'h42); load(2, 8'h43);
      run_str(630, 50, 3, 0, 2);
      run_str(636, 470, 2, 0, 3);
      load(0, 8'h41); load(1, 8'h20); load(2, 8'h42);
      run_str(0, 100, 3, 1, 4);
      for (int i = 0; i < 16; i++) load(i, $urandom_range(33, 126));
      run_str(0, 0, 20, 0, 1);
      reset_mid();
      load(0, 8'h31);
      run_str(5, 5, 1, 2, 2);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 16; i++)
            load(i, ($urandom_range(0, 3) == 0) ? 32 : $urandom_range(0, 255));
         run_str($urandom_range(0, 639), $urandom_range(0, 479),
                 $urandom_range(0, 20), $urandom_range(0, 15), 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
